// File: rtl/conv_mem_sched.sv
// conv_mem_sched: per-tile scheduler sharing one word-addressed memory port between three load FIFOs and the store FIFO.
// Define CONV_SCHED_OUT_LD_EN to let the out_fm_ld stream load out_fm_num words of partial sums.
module conv_mem_sched #(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int CW     = 16,
    parameter int MAX_OS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] in_fm_base,
    input  logic [AW-1:0] weight_base,
    input  logic [AW-1:0] out_fm_base,
    input  logic [CW-1:0] in_fm_num,
    input  logic [CW-1:0] weight_num,
    input  logic [CW-1:0] out_fm_num,
    output logic          busy,
    output logic          done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_tag,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    input  logic [1:0]    mem_rtag,
    output logic          in_fm_push,
    output logic          weight_push,
    output logic          out_fm_ld_push,
    output logic [DW-1:0] in_fm_data,
    output logic [DW-1:0] weight_data,
    output logic [DW-1:0] out_fm_ld_data,
    input  logic          in_fm_almost_full,
    input  logic          weight_almost_full,
    input  logic          out_fm_ld_almost_full,
    output logic          out_fm_st_pop,
    input  logic [DW-1:0] out_fm_st_q,
    input  logic          out_fm_st_empty
);
`ifdef CONV_SCHED_OUT_LD_EN
    localparam int NLD = 3;
`else
    localparam int NLD = 2;
`endif
    localparam int OSW = $clog2(MAX_OS + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   base_q [3];
    logic [CW-1:0]   num_q  [3];
    logic [CW-1:0]   cnt_q  [3];
    logic [CW-1:0]   st_cnt_q;
    logic [OSW-1:0]  os_q;
    logic [1:0]      ptr_q;
    logic            st_pend_q, pop_q, hold_q;
    logic [1:0]      hold_tag_q;
    logic [DW-1:0]   wdata_q, pdata_q;
    logic [NLD-1:0]  push_q;

    logic [2:0] af_s, elig_s, ld_done_s;
    logic       pop_s, ld_req_s, rd_acc_s, wr_acc_s, ret_s, all_done_s;
    logic [1:0] ld_sel_s, idx_s;

    assign af_s = {out_fm_ld_almost_full, weight_almost_full, in_fm_almost_full};

    // Per-stream eligibility and completion; streams beyond NLD never load and count as complete.
    always_comb begin
        elig_s    = 3'b000;
        ld_done_s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            ld_done_s[k] = (k >= NLD) || (cnt_q[k] == num_q[k]);
            elig_s[k]    = (state_q == S_RUN) && (k < NLD) && (cnt_q[k] < num_q[k]) &&
                           !af_s[k] && (os_q < OSW'(MAX_OS));
        end
    end

    // Store pop has priority; it waits for any held load request so that request stays stable.
    assign pop_s = (state_q == S_RUN) && (st_cnt_q < num_q[2]) && !out_fm_st_empty &&
                   !st_pend_q && !hold_q;

    // Round-robin load pick starting at ptr_q, or the request still waiting for a grant.
    always_comb begin
        ld_req_s = 1'b0;
        ld_sel_s = 2'd0;
        idx_s    = 2'd0;
        if (hold_q) begin
            ld_req_s = 1'b1;
            ld_sel_s = hold_tag_q;
        end else if (!st_pend_q && !pop_s) begin
            for (int i = NLD - 1; i >= 0; i--) begin
                idx_s = 2'((int'(ptr_q) + i) % NLD);
                if (elig_s[idx_s]) begin
                    ld_req_s = 1'b1;
                    ld_sel_s = idx_s;
                end else begin
                    ld_req_s = ld_req_s;
                end
            end
        end else begin
            ld_req_s = 1'b0;
        end
    end

    // Memory request mux: pending store first, then the selected load.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_tag  = 2'd0;
        if (st_pend_q) begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = base_q[2] + AW'(st_cnt_q);
        end else if (ld_req_s) begin
            mem_req  = 1'b1;
            mem_addr = base_q[ld_sel_s] + AW'(cnt_q[ld_sel_s]);
            mem_tag  = ld_sel_s;
        end else begin
            mem_req  = 1'b0;
        end
    end

    // The store FIFO output is valid only the cycle after pop, so pass it through until captured.
    assign mem_wdata = pop_q ? out_fm_st_q : wdata_q;

    assign rd_acc_s   = mem_req && mem_gnt && !mem_we;
    assign wr_acc_s   = mem_req && mem_gnt && mem_we;
    assign ret_s      = mem_rvalid && (state_q != S_IDLE) && (os_q != '0);
    assign all_done_s = (&ld_done_s) && (st_cnt_q == num_q[2]) && !st_pend_q && (os_q == '0);

    // Tile sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_RUN : S_IDLE;
            S_RUN:   state_d = all_done_s ? S_DONE : S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters, store handshake and registered FIFO pushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            st_cnt_q   <= '0;
            os_q       <= '0;
            ptr_q      <= 2'd0;
            st_pend_q  <= 1'b0;
            pop_q      <= 1'b0;
            hold_q     <= 1'b0;
            hold_tag_q <= 2'd0;
            wdata_q    <= '0;
            pdata_q    <= '0;
            push_q     <= '0;
            for (int k = 0; k < 3; k++) begin
                base_q[k] <= '0;
                num_q[k]  <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && start) begin
                base_q[0] <= in_fm_base;
                base_q[1] <= weight_base;
                base_q[2] <= out_fm_base;
                num_q[0]  <= in_fm_num;
                num_q[1]  <= weight_num;
                num_q[2]  <= out_fm_num;
                for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
                st_cnt_q  <= '0;
            end else begin
                if (rd_acc_s) cnt_q[ld_sel_s] <= cnt_q[ld_sel_s] + CW'(1);
                if (wr_acc_s) st_cnt_q <= st_cnt_q + CW'(1);
            end
            case ({rd_acc_s, ret_s})
                2'b10:   os_q <= os_q + OSW'(1);
                2'b01:   os_q <= os_q - OSW'(1);
                default: os_q <= os_q;
            endcase
            if (rd_acc_s) ptr_q <= 2'((int'(ld_sel_s) + 1) % NLD);
            hold_q     <= ld_req_s && !st_pend_q && !mem_gnt;
            hold_tag_q <= ld_sel_s;
            pop_q      <= pop_s;
            if (pop_s) st_pend_q <= 1'b1;
            else if (wr_acc_s) st_pend_q <= 1'b0;
            if (pop_q) wdata_q <= out_fm_st_q;
            push_q <= '0;
            if (mem_rvalid && (state_q != S_IDLE)) begin
                for (int k = 0; k < NLD; k++) begin
                    if (mem_rtag == 2'(k)) begin
                        push_q[k] <= 1'b1;
                        pdata_q   <= mem_rdata;
                    end
                end
            end
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign out_fm_st_pop = pop_s;
    assign in_fm_push    = push_q[0];
    assign weight_push   = push_q[1];
    assign in_fm_data    = pdata_q;
    assign weight_data   = pdata_q;
`ifdef CONV_SCHED_OUT_LD_EN
    assign out_fm_ld_push = push_q[2];
    assign out_fm_ld_data = pdata_q;
`else
    assign out_fm_ld_push = 1'b0;
    assign out_fm_ld_data = '0;
`endif
endmodule

// File: doc/conv_mem_sched.md
# conv_mem_sched

Tile-level memory scheduler for the convolution accelerator. Shares one external word-addressed memory port between the three load FIFOs (in_fm, weight, out_fm_ld) and the store FIFO (out_fm_st) of the conv memory interface. For each tile it issues read requests, routes tagged read returns into the correct FIFO push port, and drains results back to memory. It sits between the DDR-side port and the FIFO bank, and the tile sequencer controls it through start/done.

## Interface
Parameters:
- DW, 32, data word width (matches the FIFO bank)
- AW, 32, word address width
- CW, 16, tile word-count width
- MAX_OS, 8, maximum outstanding reads; must be ≤ FIFO depth minus the almost_full threshold

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin tile; sampled only in IDLE
- in_fm_base, weight_base, out_fm_base  in  AW each  word base addresses; out_fm_base is used for both load and store
- in_fm_num, weight_num, out_fm_num  in  CW each  word counts; latched on start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse in DONE
- mem_req  out  1  request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  word address
- mem_wdata  out  DW  write data
- mem_tag  out  2  read tag: 0 = in_fm, 1 = weight, 2 = out_fm_ld
- mem_gnt  in  1  request accepted when mem_req & mem_gnt
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DW  read data
- mem_rtag  in  2  echoed tag
- in_fm_push, weight_push, out_fm_ld_push  out  1 each  FIFO push
- in_fm_data, weight_data, out_fm_ld_data  out  DW each  FIFO write data
- in_fm_almost_full, weight_almost_full, out_fm_ld_almost_full  in  1 each
- out_fm_st_pop  out  1  store FIFO pop
- out_fm_st_q  in  DW  store FIFO output, valid the cycle after pop (non-show-ahead)
- out_fm_st_empty  in  1

## Operation
- FSM states:
  - IDLE → RUN on start. Latch bases and counts, clear the issue counters.
  - RUN → DONE when every load counter equals its count, the store counter equals out_fm_num, no store is pending, and the outstanding count is 0.
  - DONE → IDLE unconditionally.
- Store path has priority.
  - In RUN, if the store counter < out_fm_num, !out_fm_st_empty and no store is pending: assert out_fm_st_pop for 1 cycle and set st_pend.
  - Next cycle, capture out_fm_st_q into the write register and hold mem_req=1, mem_we=1, mem_addr=out_fm_base+store_cnt until mem_gnt arrives.
  - On grant, increment the store counter and clear st_pend.
- Load path, active only when no store is pending or popping:
  - A stream is eligible if its issue counter < its count, its almost_full=0, and outstanding < MAX_OS.
  - Arbitration is round-robin 0→1→2, starting after the last granted stream; the pointer advances only on an accepted read.
  - Request fields: mem_addr = base + issue counter; mem_tag = stream id. The request is held stable until granted.
- Outstanding counter:
  - +1 on an accepted read, −1 on mem_rvalid, unchanged when both occur in the same cycle.
  - Never exceeds MAX_OS.
- Read returns: mem_rvalid with mem_rtag=k gives a registered push on stream k the next cycle, with data = mem_rdata.
  - Returns with tag 3 are dropped.
  - Returns arriving in IDLE are dropped.
- A tile with all counts 0 goes RUN→DONE on the first RUN cycle.
- Address arithmetic is modulo 2^AW; wrap-around is silent.

## Timing
- Reset values: state IDLE; busy, done, mem_req, mem_we, all pushes and out_fm_st_pop = 0; mem_addr, mem_wdata, mem_tag and push data = 0; all counters = 0.
- Start sampled at cycle t gives busy=1 and the first possible mem_req at t+1.
- A store takes pop at t, then mem_req(we=1) at t+1; with mem_gnt=1 the next pop is possible at t+2.
- Read return to FIFO push latency: 1 cycle.
- start while busy is ignored.
- rst mid-tile aborts on the next edge with all outputs at their reset values; in-flight returns are dropped.

## Configuration
- CONV_SCHED_OUT_LD_EN defined: the out_fm_ld stream takes part in arbitration and loads out_fm_num words of partial sums.
- Not defined: stream 2 is never eligible, its load counter is treated as complete, out_fm_ld_push and out_fm_ld_data are tied to 0, and round-robin covers streams 0 and 1 only.

## Test plan
- in_fm_num=4, weight_num=4, out_fm_num=0, mem_gnt=1, 2-cycle read latency → reads alternate between tag 0 and tag 1; in_fm_base+0..3 and weight_base+0..3 issued; 4 pushes on each stream; done 1 cycle after the last push.
- out_fm_num=3, store FIFO holding A,B,C, no loads → 3 writes to out_fm_base+0..2 with data A,B,C in order; the pop→write spacing is 1 cycle.
- Memory never returns data with MAX_OS=8 → exactly 8 reads issued, then mem_req stays 0; each return permits exactly one more read.
- weight_almost_full held at 1 → only tag 0 (and tag 2 with the macro defined) are issued until it is released.
- All counts 0 → done pulses at start+2 with no mem_req.
- rst asserted mid-RUN with 3 reads outstanding → outputs reset the next cycle; the late returns cause no push.
